// File: rtl/detector_jogada.sv
// Key conditioning for the game datapath: two-flop synchronizer, press/release debounce FSM,
// and a registered one-hot play with single-cycle "new play" / "multiple keys" pulses.
module detector_jogada #(
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter int LARGURA         = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] chaves,
  input  logic               habilita,
  input  logic               zera,
  output logic [LARGURA-1:0] jogada,
  output logic               jogada_valida,
  output logic               multipla,
  output logic [3:0]         db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {
    INATIVO  = 2'd0,
    CONTANDO = 2'd1,
    REGISTRA = 2'd2,
    SOLTURA  = 2'd3
  } estado_t;

  estado_t            estado, estado_prox;
  logic [CW-1:0]      contador, contador_prox;
  logic [LARGURA-1:0] candidato, candidato_prox;
  logic [LARGURA-1:0] chaves_meta, chaves_sync;
  logic               um_quente;
  logic               carrega_jogada;

  always_ff @(posedge clock) begin
    if (!reset) begin
      chaves_meta <= '0;
      chaves_sync <= '0;
    end else begin
      chaves_meta <= chaves;
      chaves_sync <= chaves_meta;
    end
  end

  assign um_quente = (candidato != '0) && ((candidato & (candidato - 1'b1)) == '0);

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado    <= INATIVO;
      contador  <= '0;
      candidato <= '0;
    end else begin
      estado    <= estado_prox;
      contador  <= contador_prox;
      candidato <= candidato_prox;
    end
  end

  // Next-state logic; the counter is cleared on every state change so it never wraps.
  always_comb begin
    estado_prox    = estado;
    contador_prox  = contador;
    candidato_prox = candidato;
    carrega_jogada = 1'b0;
    case (estado)
      INATIVO: begin
        if (habilita && (chaves_sync != '0)) begin
          candidato_prox = chaves_sync;
          contador_prox  = '0;
          estado_prox    = CONTANDO;
        end
      end
      CONTANDO: begin
        if (!habilita || (chaves_sync != candidato)) begin
          contador_prox = '0;
          estado_prox   = INATIVO;
        end else if (contador == CONT_MAX) begin
          contador_prox  = '0;
          estado_prox    = REGISTRA;
          carrega_jogada = um_quente;
        end else begin
          contador_prox = contador + CW'(1);
        end
      end
      REGISTRA: begin
        contador_prox = '0;
        estado_prox   = SOLTURA;
      end
      SOLTURA: begin
        // Any key activity restarts the release window; habilita is deliberately ignored.
        if (chaves_sync != '0) begin
          contador_prox = '0;
        end else if (contador == CONT_MAX) begin
          contador_prox = '0;
          estado_prox   = INATIVO;
        end else begin
          contador_prox = contador + CW'(1);
        end
      end
      default: begin
        contador_prox = '0;
        estado_prox   = INATIVO;
      end
    endcase
  end

  // zera wins over a simultaneous load so the control unit can always clear the play.
  always_ff @(posedge clock) begin
    if (!reset) begin
      jogada <= '0;
    end else if (zera) begin
      jogada <= '0;
    end else if (carrega_jogada) begin
      jogada <= candidato;
    end
  end

  // Pulse semantics: jogada_valida/multipla are high for exactly the one REGISTRA cycle,
  // mutually exclusive, with no back-pressure; jogada is already updated in that cycle.
  always_comb begin
    jogada_valida = (estado == REGISTRA) && um_quente;
    multipla      = (estado == REGISTRA) && !um_quente;
    db_estado     = {2'b00, estado};
  end

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with DEBOUNCE_CICLOS=4: a table of press/release
// records plus hand-written sequences for latency, bounce, gating, zera and reset races.
module tb_detector_jogada;

  localparam int D = 4;
  localparam int W = 4;

  logic         clock;
  logic         reset;
  logic [W-1:0] chaves;
  logic         habilita;
  logic         zera;
  logic [W-1:0] jogada;
  logic         jogada_valida;
  logic         multipla;
  logic [3:0]   db_estado;

  detector_jogada #(.DEBOUNCE_CICLOS(D), .LARGURA(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .chaves        (chaves),
    .habilita      (habilita),
    .zera          (zera),
    .jogada        (jogada),
    .jogada_valida (jogada_valida),
    .multipla      (multipla),
    .db_estado     (db_estado)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] chaves;
    logic         habilita;
    logic [W-1:0] exp_jogada;
    int           exp_valid;
    int           exp_mult;
  } vec_t;

  vec_t vecs[8];

  int w_first_v, w_nv, w_first_m, w_nm, w_both;
  logic [3:0]   est_log[64];
  logic [W-1:0] jog_log[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs n cycles, logging state and pulses; every jogada_valida is scored against exp_q.
  task automatic watch(input int n);
    w_first_v = -1; w_nv = 0; w_first_m = -1; w_nm = 0; w_both = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      est_log[i] = db_estado;
      jog_log[i] = jogada;
      if (jogada_valida && multipla) w_both++;
      if (multipla) begin
        if (w_first_m < 0) w_first_m = i;
        w_nm++;
      end
      if (jogada_valida) begin
        if (w_first_v < 0) w_first_v = i;
        w_nv++;
        if (exp_q.size() == 0) check("unexpected_valid", 32'(jogada_valida), 32'd0);
        else check("sb_jogada", 32'(jogada), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic release_keys();
    chaves = '0;
    watch(10);
    check("release_idle", 32'(est_log[9]), 32'd0);
  endtask

  initial begin
    vecs[0] = '{4'b1000, 1'b1, 4'b1000, 1, 0};
    vecs[1] = '{4'b0011, 1'b1, 4'b1000, 0, 1};
    vecs[2] = '{4'b0100, 1'b0, 4'b1000, 0, 0};
    vecs[3] = '{4'b0010, 1'b1, 4'b0010, 1, 0};
    vecs[4] = '{4'b1111, 1'b1, 4'b0010, 0, 1};
    vecs[5] = '{4'b0001, 1'b1, 4'b0001, 1, 0};
    vecs[6] = '{4'b0110, 1'b1, 4'b0001, 0, 1};
    vecs[7] = '{4'b1000, 1'b1, 4'b1000, 1, 0};

    // reset with all keys held
    reset = 1'b0; chaves = 4'b1111; habilita = 1'b1; zera = 1'b0;
    tick(); tick();
    check("rst_jogada", 32'(jogada), 32'd0);
    check("rst_valid", 32'(jogada_valida), 32'd0);
    check("rst_mult", 32'(multipla), 32'd0);
    check("rst_estado", 32'(db_estado), 32'd0);
    reset = 1'b1;
    watch(12);
    check("rst_rel_mult_at", 32'(w_first_m), 32'd6);
    check("rst_rel_mult_n", 32'(w_nm), 32'd1);
    check("rst_rel_valid_n", 32'(w_nv), 32'd0);
    check("rst_rel_jogada", 32'(jogada), 32'd0);
    release_keys();

    // clean press: state walk and exact latency
    exp_q.push_back(4'b0100);
    chaves = 4'b0100;
    watch(20);
    check("clean_est1", 32'(est_log[1]), 32'd0);
    check("clean_est2", 32'(est_log[2]), 32'd1);
    check("clean_est5", 32'(est_log[5]), 32'd1);
    check("clean_est6", 32'(est_log[6]), 32'd2);
    check("clean_est7", 32'(est_log[7]), 32'd3);
    check("clean_est19", 32'(est_log[19]), 32'd3);
    check("clean_valid_at", 32'(w_first_v), 32'd6);
    check("clean_valid_n", 32'(w_nv), 32'd1);
    check("clean_jog6", 32'(jog_log[6]), 32'b0100);
    chaves = '0;
    watch(10);
    check("clean_rel_est3", 32'(est_log[3]), 32'd3);
    check("clean_rel_est6", 32'(est_log[6]), 32'd0);

    // bounce: 3 on, 1 off, then stable
    exp_q.push_back(4'b0001);
    chaves = 4'b0001; tick(); tick(); tick();
    chaves = 4'b0000; tick();
    chaves = 4'b0001;
    watch(16);
    check("bounce_valid_at", 32'(w_first_v), 32'd6);
    check("bounce_valid_n", 32'(w_nv), 32'd1);
    check("bounce_jogada", 32'(jogada), 32'b0001);
    release_keys();

    // table of press/release records
    for (int v = 0; v < 8; v++) begin
      habilita = vecs[v].habilita;
      chaves = vecs[v].chaves;
      if (vecs[v].exp_valid == 1) exp_q.push_back(vecs[v].exp_jogada);
      watch(12);
      check($sformatf("vec%0d_valid_n", v), 32'(w_nv), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_mult_n", v), 32'(w_nm), 32'(vecs[v].exp_mult));
      check($sformatf("vec%0d_exclusive", v), 32'(w_both), 32'd0);
      check($sformatf("vec%0d_jogada", v), 32'(jogada), 32'(vecs[v].exp_jogada));
      if (vecs[v].exp_valid == 1) check($sformatf("vec%0d_valid_at", v), 32'(w_first_v), 32'd6);
      if (vecs[v].exp_mult == 1) check($sformatf("vec%0d_mult_at", v), 32'(w_first_m), 32'd6);
      habilita = 1'b1;
      release_keys();
      check($sformatf("vec%0d_sb_empty", v), 32'(exp_q.size()), 32'd0);
    end

    // enable gating
    habilita = 1'b0; chaves = 4'b0010;
    watch(10);
    check("gate_off_pulses", 32'(w_nv + w_nm), 32'd0);
    check("gate_off_est", 32'(est_log[9]), 32'd0);
    exp_q.push_back(4'b0010);
    habilita = 1'b1;
    watch(8);
    check("gate_on_valid_at", 32'(w_first_v), 32'd4);
    check("gate_on_valid_n", 32'(w_nv), 32'd1);
    check("gate_on_jogada", 32'(jogada), 32'b0010);
    release_keys();
    chaves = 4'b0100;
    watch(3);
    check("gate_drop_est_pre", 32'(est_log[2]), 32'd1);
    habilita = 1'b0;
    watch(10);
    check("gate_drop_est", 32'(est_log[0]), 32'd0);
    check("gate_drop_pulses", 32'(w_nv + w_nm), 32'd0);
    check("gate_drop_jogada", 32'(jogada), 32'b0010);
    chaves = '0; habilita = 1'b1;
    watch(4);

    // zera on the edge entering REGISTRA
    exp_q.push_back(4'b0000);
    chaves = 4'b0100;
    watch(6);
    zera = 1'b1;
    watch(1);
    zera = 1'b0;
    check("zera_valid", 32'(w_nv), 32'd1);
    check("zera_jogada", 32'(jog_log[0]), 32'd0);
    watch(4);
    check("zera_jogada_after", 32'(jogada), 32'd0);
    release_keys();

    // reset during CONTANDO, key still held afterwards
    chaves = 4'b1000;
    watch(4);
    check("rstc_est_pre", 32'(est_log[3]), 32'd1);
    reset = 1'b0;
    tick();
    check("rstc_estado", 32'(db_estado), 32'd0);
    check("rstc_jogada", 32'(jogada), 32'd0);
    check("rstc_valid", 32'(jogada_valida), 32'd0);
    reset = 1'b1;
    exp_q.push_back(4'b1000);
    watch(10);
    check("rstc_valid_at", 32'(w_first_v), 32'd6);
    check("rstc_valid_n", 32'(w_nv), 32'd1);
    release_keys();

    // key change while waiting for release
    exp_q.push_back(4'b0001);
    chaves = 4'b0001;
    watch(9);
    check("solt_first_n", 32'(w_nv), 32'd1);
    chaves = 4'b0011;
    watch(6);
    check("solt_add_pulses", 32'(w_nv + w_nm), 32'd0);
    chaves = 4'b0001;
    watch(6);
    check("solt_back_pulses", 32'(w_nv + w_nm), 32'd0);
    check("solt_est", 32'(est_log[5]), 32'd3);
    release_keys();

    check("sb_final_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
